// File: rtl/deserializer.sv
// deserializer: MSB-first serial-to-parallel converter with a one-cycle word-valid pulse.
// Optional even-parity trailer bit and error flag when DESER_PARITY_EN is defined.
module deserializer #(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             data_i,
  input  logic             data_val_i,
  output logic [WIDTH-1:0] deser_data_o,
  output logic             deser_data_val_o,
  output logic             parity_err_o
);
`ifdef DESER_PARITY_EN
  localparam int FL = WIDTH + 1;
`else
  localparam int FL = WIDTH;
`endif
  localparam int SW = FL - 1;
  localparam int CW = $clog2(FL + 1);
  logic [SW-1:0]    sr;
  logic [CW-1:0]    cnt;
  logic             last;
  logic [WIDTH-1:0] word;
  assign last = data_val_i && (cnt == CW'(FL - 1));
`ifdef DESER_PARITY_EN
  assign word = sr;
`else
  assign word = {sr, data_i};
  assign parity_err_o = 1'b0;
`endif
  // The final bit is taken straight from data_i, so sr only ever holds FL-1 bits.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sr               <= '0;
      cnt              <= '0;
      deser_data_o     <= '0;
      deser_data_val_o <= 1'b0;
`ifdef DESER_PARITY_EN
      parity_err_o     <= 1'b0;
`endif
    end else begin
      deser_data_val_o <= last;
`ifdef DESER_PARITY_EN
      parity_err_o     <= last && ((^sr) ^ data_i);
`endif
      if (data_val_i) cnt <= last ? '0 : cnt + 1'b1;
      if (data_val_i && !last) sr <= SW'({sr, data_i});
      if (last) deser_data_o <= word;
    end
  end
endmodule

// File: tb/tb_deserializer.sv
// tb_deserializer: directed checks of framing, gaps, back-to-back frames, reset and parity.
module tb_deserializer;
  localparam int W = 16;
`ifdef DESER_PARITY_EN
  localparam int FL = W + 1;
`else
  localparam int FL = W;
`endif
  logic         clk = 1'b0;
  logic         rst_i = 1'b1;
  logic         data_i = 1'b0;
  logic         data_val_i = 1'b0;
  logic [W-1:0] deser_data_o;
  logic         deser_data_val_o;
  logic         parity_err_o;
  int           errs = 0;
  int           checks = 0;
  int           cyc = 0;
  int           pulse_cyc = 0;
  int           first_pulse = 0;

  deserializer #(.WIDTH(W)) dut (
    .clk_i(clk), .rst_i(rst_i), .data_i(data_i), .data_val_i(data_val_i),
    .deser_data_o(deser_data_o), .deser_data_val_o(deser_data_val_o),
    .parity_err_o(parity_err_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Sends one frame MSB first; optional idle cycle after every non-final bit.
  task automatic send(input logic [W-1:0] w, input bit gaps, input logic [W-1:0] hold,
                      input bit bad_par);
    logic [W:0] f;
    int n;
`ifdef DESER_PARITY_EN
    f = {w, (^w) ^ bad_par};
    n = W + 1;
`else
    f = {1'b0, w};
    n = W;
`endif
    for (int i = n - 1; i >= 0; i--) begin
      data_i = f[i];
      data_val_i = 1'b1;
      tick();
      if (i > 0) begin
        chk("no_pulse_mid_frame", 32'(deser_data_val_o), 32'd0);
        chk("hold_mid_frame", 32'(deser_data_o), 32'(hold));
        if (gaps) begin
          data_val_i = 1'b0;
          data_i = ~data_i;
          tick();
          chk("no_pulse_gap", 32'(deser_data_val_o), 32'd0);
          chk("hold_gap", 32'(deser_data_o), 32'(hold));
        end
      end
    end
    chk("pulse", 32'(deser_data_val_o), 32'd1);
    chk("word", 32'(deser_data_o), 32'(w));
`ifdef DESER_PARITY_EN
    chk("parity_err", 32'(parity_err_o), 32'(bad_par));
`else
    chk("parity_err", 32'(parity_err_o), 32'd0);
`endif
    pulse_cyc = cyc;
  endtask

  task automatic idle_check(input logic [W-1:0] hold);
    data_val_i = 1'b0;
    tick();
    chk("pulse_ends", 32'(deser_data_val_o), 32'd0);
    chk("parity_idle", 32'(parity_err_o), 32'd0);
    chk("hold_idle", 32'(deser_data_o), 32'(hold));
  endtask

  initial begin
    // Reset with valid ones presented: all discarded.
    data_i = 1'b1;
    data_val_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_data", 32'(deser_data_o), 32'h0);
      chk("rst_val", 32'(deser_data_val_o), 32'd0);
      chk("rst_par", 32'(parity_err_o), 32'd0);
    end
    rst_i = 1'b0;
    data_val_i = 1'b0;
    send(16'hA5C3, 1'b0, 16'h0000, 1'b0);
    idle_check(16'hA5C3);
    idle_check(16'hA5C3);
    // Gapped frame.
    send(16'h8001, 1'b1, 16'hA5C3, 1'b0);
    idle_check(16'h8001);
    // Back-to-back frames with valid held high.
    send(16'h0001, 1'b0, 16'h8001, 1'b0);
    first_pulse = pulse_cyc;
    send(16'hFFFF, 1'b0, 16'h0001, 1'b0);
    chk("b2b_spacing", 32'(pulse_cyc - first_pulse), 32'(FL));
    idle_check(16'hFFFF);
    // Mid-frame reset after 7 bits.
    for (int i = 0; i < 7; i++) begin
      data_i = 1'b1;
      data_val_i = 1'b1;
      tick();
      chk("partial_no_pulse", 32'(deser_data_val_o), 32'd0);
    end
    rst_i = 1'b1;
    tick();
    chk("midrst_data", 32'(deser_data_o), 32'h0);
    chk("midrst_val", 32'(deser_data_val_o), 32'd0);
    rst_i = 1'b0;
    data_val_i = 1'b0;
    tick();
    send(16'h1234, 1'b0, 16'h0000, 1'b0);
    idle_check(16'h1234);
`ifdef DESER_PARITY_EN
    send(16'h0003, 1'b0, 16'h1234, 1'b0);
    idle_check(16'h0003);
    send(16'h0003, 1'b0, 16'h0003, 1'b1);
    idle_check(16'h0003);
`endif
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
